piano_voice_mixer: RTL

Seven-voice tone synthesizer between the piano key inputs (SW[6:0] and learn-mode highlight logic) and the Audio_Controller's DAC FIFO. It replaces the ad-hoc per-note square-wave counters with per-voice phase counters and attack/release envelopes, which removes clicks on key press and release. It sums the voices into one signed 32-bit sample at a fixed sample rate. It delivers samples using the FIFO's `audio_out_allowed` / `write_audio_out` handshake.

---
 rtl/piano_pkg.sv | 32 +++
 rtl/piano_voice_mixer_voice.sv | 62 ++++++
 rtl/piano_voice_mixer.sv | 100 ++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared constants for the seven-voice piano synthesizer.
// Voice index 6 is C, index 0 is B, matching the key_on bit order.
package piano_pkg;

   localparam int NUM_VOICES = 7;
   localparam int HP_W = 17;

   typedef logic [HP_W-1:0] hp_t;
   typedef hp_t [NUM_VOICES-1:0] hp_arr_t;

   localparam int V_B = 0;
   localparam int V_A = 1;
   localparam int V_G = 2;
   localparam int V_F = 3;
   localparam int V_E = 4;
   localparam int V_D = 5;
   localparam int V_C = 6;

   // Half tone period in CLOCK_50 cycles, C (msb) .. B (lsb)
   localparam hp_arr_t HALF_PERIOD_DEF = {
      17'd96000, 17'd86000, 17'd76000, 17'd71500,
      17'd64000, 17'd57000, 17'd51000
   };

   function automatic logic [31:0] voice_amp(
      input logic [7:0] env,
      input int unsigned shift
   );
      return 32'(env) << shift;
   endfunction

endpackage

// File: rtl/piano_voice_mixer_voice.sv
// One tone voice: square-wave phase counter with an attack/release
// envelope, producing a signed amplitude sample.
module piano_voice
   import piano_pkg::*;
#(
   parameter int unsigned HALF         = 51000,
   parameter int unsigned ENV_MAX      = 255,
   parameter int unsigned ATTACK_STEP  = 16,
   parameter int unsigned RELEASE_STEP = 4,
   parameter int unsigned AMP_SHIFT    = 19
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               key,
   input  logic               tick,
   output logic               active,
   output logic signed [31:0] value
);

   logic [HP_W-1:0] cnt;
   logic            phase;
   logic [7:0]      env;
   logic            idle;
   logic [8:0]      up;
   logic [31:0]     amp;

   // A silent, released voice parks its oscillator so the next press
   // always starts from the same phase.
   assign idle = !key && (env == '0);
   assign up   = {1'b0, env} + 9'(ATTACK_STEP);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (idle) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == HP_W'(HALF - 1)) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         env <= '0;
      end else if (tick) begin
         if (key)
            env <= (up > 9'(ENV_MAX)) ? 8'(ENV_MAX) : up[7:0];
         else
            env <= (env > 8'(RELEASE_STEP)) ? env - 8'(RELEASE_STEP) : '0;
      end
   end

   assign amp    = voice_amp(env, AMP_SHIFT);
   assign value  = phase ? signed'(amp) : -signed'(amp);
   assign active = |env;

endmodule

// File: rtl/piano_voice_mixer.sv
// Seven-voice mixer: key synchronizer, sample-rate tick, voice sum and
// a one-deep sample register drained through the DAC FIFO handshake.
module piano_voice_mixer
   import piano_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV   = 1042,
   parameter int unsigned ENV_MAX      = 255,
   parameter int unsigned ATTACK_STEP  = 16,
   parameter int unsigned RELEASE_STEP = 4,
   parameter int unsigned AMP_SHIFT    = 19,
   parameter hp_arr_t     HALF_PERIOD  = HALF_PERIOD_DEF
) (
   input  logic                  CLOCK_50,
   input  logic                  resetn,
   input  logic [NUM_VOICES-1:0] key_on,
   input  logic                  audio_out_allowed,
   output logic                  write_audio_out,
   output logic [31:0]           left_channel_audio_out,
   output logic [31:0]           right_channel_audio_out,
   output logic [NUM_VOICES-1:0] voice_active,
   output logic                  overrun
);

   localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [NUM_VOICES-1:0] sync1;
   logic [NUM_VOICES-1:0] k;
   logic [CW-1:0]         cnt;
   logic                  tick;
   logic                  pending;
   logic signed [31:0]    sample;
   logic signed [31:0]    sum;
   logic signed [31:0]    value [NUM_VOICES];

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         sync1 <= '0;
         k     <= '0;
      end else begin
         sync1 <= key_on;
         k     <= sync1;
      end
   end

   assign tick = (cnt == CW'(SAMPLE_DIV - 1));

   always_ff @(posedge CLOCK_50) begin
      if (!resetn)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      piano_voice #(
         .HALF         (int'(HALF_PERIOD[g])),
         .ENV_MAX      (ENV_MAX),
         .ATTACK_STEP  (ATTACK_STEP),
         .RELEASE_STEP (RELEASE_STEP),
         .AMP_SHIFT    (AMP_SHIFT)
      ) u_voice (
         .clk    (CLOCK_50),
         .resetn (resetn),
         .key    (k[g]),
         .tick   (tick),
         .active (voice_active[g]),
         .value  (value[g])
      );
   end

   // Worst case 7*255*2^19 fits in 31 bits, so a plain 32-bit sum is safe
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         sum = sum + value[i];
   end

   assign write_audio_out = pending && audio_out_allowed;

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         sample  <= '0;
         pending <= 1'b0;
         overrun <= 1'b0;
      end else if (tick) begin
         sample  <= sum;
         pending <= 1'b1;
         if (pending && !write_audio_out)
            overrun <= 1'b1;
      end else if (write_audio_out) begin
         pending <= 1'b0;
      end
   end

   assign left_channel_audio_out  = sample;
   assign right_channel_audio_out = sample;

endmodule
